// File: rtl/monopulse_pkg.sv
// Shared definitions for the monopulse datapath: sample width and the
// capture FSM state encoding used by memory_writer.
package monopulse_pkg;

  localparam int DATA_SIZE = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } writer_state_t;

endpackage

// File: rtl/memory_writer_if.sv
// Capture/readback bus of memory_writer: sample stream in, status and
// random-access read port out.
interface memory_writer_if
  import monopulse_pkg::*;
#(
  parameter int DATA_SIZE = monopulse_pkg::DATA_SIZE,
  parameter int ADDR_SIZE = 10
);

  logic                 i_start;
  logic                 i_valid;
  logic [DATA_SIZE-1:0] i_data;
  logic [ADDR_SIZE-1:0] i_rd_addr;
  logic [DATA_SIZE-1:0] o_rd_data;
  logic [ADDR_SIZE:0]   o_count;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_overflow;

  modport slave (
    input  i_start, i_valid, i_data, i_rd_addr,
    output o_rd_data, o_count, o_busy, o_done, o_overflow
  );

  modport master (
    output i_start, i_valid, i_data, i_rd_addr,
    input  o_rd_data, o_count, o_busy, o_done, o_overflow
  );

endinterface

// File: rtl/capture_ram.sv
// Simple dual-port storage: one write port, one registered read-first read
// port whose output register clears on srst (contents are never cleared).
module capture_ram #(
  parameter int DATA_SIZE = 64,
  parameter int DEPTH     = 1024
) (
  input  logic                         clk,
  input  logic                         srst,
  input  logic                         wr_en,
  input  logic [$clog2(DEPTH)-1:0]     wr_addr,
  input  logic [DATA_SIZE-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0]     rd_addr,
  output logic [DATA_SIZE-1:0]         rd_data
);

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [DATA_SIZE-1:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read samples the array before this edge's write lands: read-first.
  always_ff @(posedge clk) begin
    if (srst) begin
      rd_data_reg <= '0;
    end else begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/memory_writer.sv
// Capture buffer for the monopulse relation stream. Optional keep-one-in-N
// decimation is enabled with `define MEMORY_WRITER_DECIMATE_EN.
module memory_writer
  import monopulse_pkg::*;
#(
  parameter int DATA_SIZE  = monopulse_pkg::DATA_SIZE,
  parameter int DEPTH      = 1024,
  parameter int ADDR_SIZE  = $clog2(DEPTH),
  parameter int DECIMATION = 4
) (
  input  logic           i_clock,
  input  logic           i_reset,
  memory_writer_if.slave bus
);

  localparam int CNT_W = ADDR_SIZE + 1;

  writer_state_t        state_reg, state_next;
  logic [ADDR_SIZE-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0]     count_reg, count_next;
  logic                 overflow_reg, overflow_next;
  logic                 busy_reg, done_reg;
  logic                 wr_en;
  logic                 keep_sample;
  logic                 start_accepted;

  assign start_accepted = bus.i_start && (state_reg != CAPTURE);

`ifdef MEMORY_WRITER_DECIMATE_EN
  localparam int DEC_W = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;

  logic [DEC_W-1:0] dec_reg, dec_next;

  assign keep_sample = (dec_reg == '0);

  always_comb begin
    dec_next = dec_reg;
    if (start_accepted) begin
      dec_next = '0;
    end else if (state_reg == CAPTURE && bus.i_valid) begin
      dec_next = (dec_reg == DEC_W'(DECIMATION - 1)) ? '0 : dec_reg + DEC_W'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      dec_reg <= '0;
    end else begin
      dec_reg <= dec_next;
    end
  end
`else
  // Every valid sample is kept; a ratio below 1 is meaningless.
  assign keep_sample = (DECIMATION > 0);
`endif

  always_comb begin
    state_next    = state_reg;
    wr_ptr_next   = wr_ptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;
    wr_en         = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (bus.i_start) begin
          state_next    = CAPTURE;
          wr_ptr_next   = '0;
          count_next    = '0;
          overflow_next = 1'b0;
        end
      end
      CAPTURE: begin
        if (bus.i_valid && keep_sample) begin
          wr_en      = 1'b1;
          count_next = count_reg + CNT_W'(1);
          // The pointer parks on the last word instead of wrapping.
          if (wr_ptr_reg == ADDR_SIZE'(DEPTH - 1)) begin
            state_next = DONE;
          end else begin
            wr_ptr_next = wr_ptr_reg + ADDR_SIZE'(1);
          end
        end
      end
      DONE: begin
        if (bus.i_start) begin
          state_next    = CAPTURE;
          wr_ptr_next   = '0;
          count_next    = '0;
          overflow_next = 1'b0;
        end else if (bus.i_valid) begin
          overflow_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
      busy_reg     <= (state_next == CAPTURE);
      done_reg     <= (state_next == DONE);
    end
  end

  capture_ram #(
    .DATA_SIZE (DATA_SIZE),
    .DEPTH     (DEPTH)
  ) u_capture_ram (
    .clk     (i_clock),
    .srst    (i_reset),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_reg),
    .wr_data (bus.i_data),
    .rd_addr (bus.i_rd_addr),
    .rd_data (bus.o_rd_data)
  );

  assign bus.o_count    = count_reg;
  assign bus.o_busy     = busy_reg;
  assign bus.o_done     = done_reg;
  assign bus.o_overflow = overflow_reg;

endmodule

// File: tb/tb_memory_writer.sv
// Directed bench for memory_writer with DEPTH=8, DECIMATION=4; the
// decimation scenario runs when MEMORY_WRITER_DECIMATE_EN is defined.
module tb_memory_writer;

  localparam int DEPTH     = 8;
  localparam int ADDR_SIZE = 3;
  localparam int DSZ       = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int tests_run    = 0;
  int tests_failed = 0;

  memory_writer_if #(.DATA_SIZE(DSZ), .ADDR_SIZE(ADDR_SIZE)) bus ();

  memory_writer #(
    .DATA_SIZE  (DSZ),
    .DEPTH      (DEPTH),
    .ADDR_SIZE  (ADDR_SIZE),
    .DECIMATION (4)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d);
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    tick();
    bus.i_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
  endtask

  task automatic read_check(input string tag, input int addr, input logic [63:0] exp);
    bus.i_rd_addr = ADDR_SIZE'(addr);
    tick();
    check(tag, bus.o_rd_data, exp);
  endtask

  initial begin
    bus.i_start   = 1'b0;
    bus.i_valid   = 1'b0;
    bus.i_data    = '0;
    bus.i_rd_addr = '0;

    // Reset state observed while reset is still held
    tick();
    tick();
    check("rst_count", 64'(bus.o_count), 64'd0);
    check("rst_busy", 64'(bus.o_busy), 64'd0);
    check("rst_done", 64'(bus.o_done), 64'd0);
    check("rst_ovf", 64'(bus.o_overflow), 64'd0);
    check("rst_rd_data", bus.o_rd_data, 64'd0);
    rst = 1'b0;
    tick();

`ifndef MEMORY_WRITER_DECIMATE_EN
    // Basic fill
    pulse_start();
    check("fill_busy", 64'(bus.o_busy), 64'd1);
    check("fill_count0", 64'(bus.o_count), 64'd0);
    for (int i = 0; i < DEPTH; i++) begin
      send(64'h10 + 64'(i));
      if (i == DEPTH - 2) check("fill_done_early", 64'(bus.o_done), 64'd0);
    end
    check("fill_done", 64'(bus.o_done), 64'd1);
    check("fill_count", 64'(bus.o_count), 64'd8);
    check("fill_busy_low", 64'(bus.o_busy), 64'd0);
    for (int i = 0; i < DEPTH; i++) read_check("fill_rd", i, 64'h10 + 64'(i));

    // Overflow in DONE
    send(64'hDEAD);
    check("ovf_set", 64'(bus.o_overflow), 64'd1);
    tick();
    check("ovf_sticky", 64'(bus.o_overflow), 64'd1);
    check("ovf_done_held", 64'(bus.o_done), 64'd1);
    read_check("ovf_mem0", 0, 64'h10);
    pulse_start();
    check("restart_ovf", 64'(bus.o_overflow), 64'd0);
    check("restart_done", 64'(bus.o_done), 64'd0);
    check("restart_count", 64'(bus.o_count), 64'd0);
    check("restart_busy", 64'(bus.o_busy), 64'd1);

    // Start ignored while capturing; same-cycle valid is written
    send(64'h20);
    send(64'h21);
    check("busy_start_cnt2", 64'(bus.o_count), 64'd2);
    bus.i_start = 1'b1;
    send(64'h22);
    bus.i_start = 1'b0;
    check("busy_start_cnt3", 64'(bus.o_count), 64'd3);
    send(64'h23);
    check("busy_start_cnt4", 64'(bus.o_count), 64'd4);
    for (int i = 4; i < DEPTH; i++) send(64'h20 + 64'(i));
    check("busy_start_done", 64'(bus.o_done), 64'd1);
    check("busy_start_count", 64'(bus.o_count), 64'd8);
    for (int i = 0; i < DEPTH; i++) read_check("busy_start_rd", i, 64'h20 + 64'(i));

    // Start and valid together in DONE: restart wins, sample dropped
    bus.i_start = 1'b1;
    send(64'hEE);
    bus.i_start = 1'b0;
    check("done_startvalid_cnt", 64'(bus.o_count), 64'd0);
    check("done_startvalid_ovf", 64'(bus.o_overflow), 64'd0);
    check("done_startvalid_busy", 64'(bus.o_busy), 64'd1);

    // Gapped valid into the capture just started
    for (int i = 0; i < DEPTH; i++) begin
      send(64'h10 + 64'(i));
      if (i == DEPTH - 1) check("gap_done", 64'(bus.o_done), 64'd1);
      tick();
      if (i == DEPTH - 2) check("gap_done_early", 64'(bus.o_done), 64'd0);
    end
    check("gap_count", 64'(bus.o_count), 64'd8);
    for (int i = 0; i < DEPTH; i++) read_check("gap_rd", i, 64'h10 + 64'(i));

    // Reset mid-capture, then valid in IDLE
    pulse_start();
    send(64'hA0);
    send(64'hA1);
    send(64'hA2);
    check("mid_count3", 64'(bus.o_count), 64'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_count", 64'(bus.o_count), 64'd0);
    check("mid_rst_busy", 64'(bus.o_busy), 64'd0);
    check("mid_rst_done", 64'(bus.o_done), 64'd0);
    send(64'hBB);
    send(64'hBC);
    check("idle_valid_count", 64'(bus.o_count), 64'd0);
    check("idle_valid_busy", 64'(bus.o_busy), 64'd0);
    read_check("mid_rd0", 0, 64'hA0);
    read_check("mid_rd1", 1, 64'hA1);
    read_check("mid_rd2", 2, 64'hA2);
    read_check("mid_rd3", 3, 64'h13);
`else
    // Decimated capture: keep 0, 4, ..., 28
    pulse_start();
    for (int v = 0; v < 32; v++) begin
      send(64'(v));
      if (v == 27) check("dec_done_early", 64'(bus.o_done), 64'd0);
      if (v == 28) begin
        check("dec_done", 64'(bus.o_done), 64'd1);
        check("dec_count", 64'(bus.o_count), 64'd8);
      end
    end
    check("dec_ovf", 64'(bus.o_overflow), 64'd1);
    for (int i = 0; i < DEPTH; i++) read_check("dec_rd", i, 64'(4 * i));
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/memory_writer.md
Name: memory_writer

Overview:
- Capture buffer that stores the 64-bit monopulse relation stream into an on-chip memory.
- It is the write-side counterpart of memory_reader: memory_reader sources reference/error samples, and memory_writer sinks o_relation results from monopulse.
- It runs on the clocking-wizard output clock alongside both blocks.
- A random-access read port exposes captured results to the bench or host after capture completes.

Parameters:
- DATA_SIZE, 64, width of each captured sample.
- DEPTH, 1024, number of memory words; must be a power of two, at least 2.
- ADDR_SIZE, $clog2(DEPTH), address and pointer width.
- DECIMATION, 4, keep ratio; used only when MEMORY_WRITER_DECIMATE_EN is defined; must be at least 1.

Ports:
- i_clock  input  1  system clock (clocking-wizard output).
- i_reset  input  1  synchronous, active-high reset.
- i_start  input  1  one-cycle pulse that arms a new capture.
- i_valid  input  1  i_data qualifier; sampled every cycle.
- i_data  input  DATA_SIZE  result sample (monopulse o_relation).
- i_rd_addr  input  ADDR_SIZE  read-port address.
- o_rd_data  output  DATA_SIZE  registered read data.
- o_count  output  ADDR_SIZE+1  number of words written in the current capture.
- o_busy  output  1  high while capturing.
- o_done  output  1  high once the buffer is full.
- o_overflow  output  1  sticky flag: a valid sample arrived while in DONE.

Behaviour:
- Reset (synchronous, active-high, wins over every other input):
  - State goes to IDLE.
  - o_count=0, o_busy=0, o_done=0, o_overflow=0, o_rd_data=0.
  - Memory contents are not cleared.
- States are IDLE, CAPTURE and DONE.
- IDLE:
  - i_valid is ignored.
  - i_start moves to CAPTURE next cycle; write pointer and o_count are cleared to 0.
- CAPTURE:
  - o_busy=1.
  - Each cycle with i_valid=1 writes i_data to mem[wr_ptr]; wr_ptr and o_count increment at that clock edge.
  - The write at wr_ptr==DEPTH-1 moves the state to DONE, with o_count=DEPTH. The pointer does not wrap.
  - i_start during CAPTURE is ignored; there is no restart mid-capture.
  - If i_valid and i_start arrive in the same cycle, the valid sample is written.
- DONE:
  - o_busy=0, o_done=1.
  - No writes occur.
  - i_valid=1 sets o_overflow, which stays set until the next accepted i_start or reset.
  - i_start re-enters CAPTURE and clears o_done, o_overflow, o_count and wr_ptr.
  - If i_start and i_valid arrive in the same cycle in DONE, the restart wins. That sample is dropped and o_overflow is not set.
- Read port:
  - o_rd_data <= mem[i_rd_addr] every cycle; one-cycle latency in every state.
  - Read and write to the same address in the same cycle returns the old data (read-first).
- Flag timing: all outputs are registered. o_done rises in the cycle after the final write edge.
- Reset mid-capture aborts immediately. Words already written stay in memory; o_count reads 0.

Optional Feature:
- Macro: MEMORY_WRITER_DECIMATE_EN.
- Defined:
  - A modulo-DECIMATION counter advances on each valid sample in CAPTURE.
  - Only samples at counter==0 are written, so the first valid after start is kept, then every DECIMATION-th.
  - The counter clears on start and on reset.
  - o_count counts written words only. DONE is reached after DEPTH written words.
  - Overflow detection in DONE is unchanged.
- Undefined: every valid sample in CAPTURE is written, and the DECIMATION parameter is unused.

Decomposition:
- Package monopulse_pkg holds:
  - DATA_SIZE=64, shared with memory_reader and monopulse.
  - The writer_state_t enum {IDLE, CAPTURE, DONE}.
- Sub-module capture_ram holds the storage:
  - Simple dual-port RAM: one write port, one synchronous read port, read-first, inferable as BRAM.
  - Parameters DATA_SIZE and DEPTH.
- memory_writer contains the FSM, pointer, counters and flags.

Test Plan (DEPTH=8, DECIMATION=4):
- Basic fill:
  - Stimulus: reset, start pulse, 8 valid samples 0x10..0x17 on consecutive cycles.
  - Required: o_done=1 one cycle after the 8th edge, o_count=8, o_busy=0.
  - Readback: addresses 0..7 return 0x10..0x17, each one cycle after its address is applied.
- Gapped valid: same capture with i_valid toggling every other cycle → identical memory contents, and o_done asserts after the 8th accepted sample.
- Overflow:
  - Stimulus: after DONE, i_valid=1 with data 0xDEAD.
  - Required: o_overflow=1 and sticky; mem[0] still 0x10.
  - Then a start pulse → o_overflow=0, o_done=0, o_count=0, o_busy=1.
- Reset mid-capture:
  - Stimulus: start, 3 samples 0xA0..0xA2, then i_reset for 1 cycle.
  - Required: state IDLE, o_count=0, o_busy=0; mem[0..2] still read 0xA0..0xA2.
  - Valid samples in IDLE are not written.
- Start ignored while busy: i_start during CAPTURE after 2 writes → o_count continues 3, 4, …; no pointer reset.
- With MEMORY_WRITER_DECIMATE_EN:
  - Stimulus: 32 consecutive samples 0..31.
  - Required: memory holds 0, 4, 8, …, 28; o_done after the sample with value 28.
